// File: rtl/soqpsk_trellis_demod.sv
// 4-state SOQPSK trellis demodulator: ACS metric update, register-exchange traceback, loop error terms.
// Define SOQPSK_ODD_ERR_EN to refresh errEn/phaseError/devError on every symbol instead of even symbols only.
module soqpsk_trellis_demod #(
  parameter int MF_W     = 8,
  parameter int ERR_W    = 10,
  parameter int TB_DEPTH = 16,
  parameter int ACC_W    = MF_W + 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               symEn,
  input  logic [4*MF_W-1:0]  mfZrReal,
  input  logic [4*MF_W-1:0]  mfPrReal,
  input  logic [4*MF_W-1:0]  mfMrReal,
  input  logic [4*ERR_W-1:0] mfZrImag,
  input  logic [4*ERR_W-1:0] mfPrImag,
  input  logic [4*ERR_W-1:0] mfMrImag,
  output logic               decision,
  output logic               decEn,
  output logic [1:0]         bestState,
  output logic [ERR_W-1:0]   phaseError,
  output logic [ERR_W-1:0]   devError,
  output logic               errEn,
  output logic               symParity
);
  localparam int SW   = ACC_W + 2;
  localparam int FC_W = $clog2(TB_DEPTH + 1);

  // Trellis tables, entry [s] for state s: zero-branch rotation, one-branch source state / rotation / Pr-vs-Mr.
  localparam logic [3:0][1:0] ZR_ROT  = {2'd1, 2'd0, 2'd2, 2'd3};
  localparam logic [3:0][1:0] EV_PRED = {2'd1, 2'd0, 2'd3, 2'd2};
  localparam logic [3:0][1:0] EV_ROT  = {2'd2, 2'd3, 2'd1, 2'd0};
  localparam logic [3:0]      EV_PR   = 4'b0110;
  localparam logic [3:0][1:0] OD_PRED = {2'd2, 2'd3, 2'd0, 2'd1};
  localparam logic [3:0][1:0] OD_ROT  = {2'd0, 2'd1, 2'd3, 2'd2};
  localparam logic [3:0]      OD_PR   = 4'b1001;

  function automatic logic signed [SW-1:0] sx_mf(input logic [MF_W-1:0] v);
    return {{(SW-MF_W){v[MF_W-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] sx_acc(input logic [ACC_W-1:0] v);
    return {{(SW-ACC_W){v[ACC_W-1]}}, v};
  endfunction

  logic signed [ACC_W-1:0] r_acc [4];
  logic [TB_DEPTH-1:0]     r_path [4];
  logic signed [ERR_W-1:0] r_img [4];
  logic [3:0]              r_sel;
  logic [1:0]              r_best;
  logic [FC_W-1:0]         r_fill;
  logic                    r_parity, r_vld1, r_even1;
  logic                    r_dec, r_decEn, r_errEn;
  logic [ERR_W-1:0]        r_phase, r_dev;

  logic signed [ACC_W-1:0] w_new [4];
  logic signed [ERR_W-1:0] w_img [4];
  logic [1:0]              w_pred [4];
  logic [3:0]              w_sel;
  logic signed [ACC_W-1:0] w_bestPrev, w_maxNew;
  logic [1:0]              w_bestNew;
  logic signed [ERR_W-1:0] w_phase, w_neg;
  logic                    w_errUpd;

  for (genvar s = 0; s < 4; s++) begin : g_acs
    localparam int ZK = int'(ZR_ROT[s]);
    localparam int EP = int'(EV_PRED[s]);
    localparam int EK = int'(EV_ROT[s]);
    localparam int OP = int'(OD_PRED[s]);
    localparam int OK = int'(OD_ROT[s]);
    logic signed [SW-1:0]    w_c0, w_ev, w_od, w_c1, w_win, w_diff;
    logic signed [ERR_W-1:0] w_evI, w_odI;

    assign w_c0  = sx_acc(r_acc[s]) + sx_mf(mfZrReal[ZK*MF_W +: MF_W]);
    assign w_ev  = sx_acc(r_acc[EP]) + sx_mf(EV_PR[s] ? mfPrReal[EK*MF_W +: MF_W] : mfMrReal[EK*MF_W +: MF_W]);
    assign w_od  = sx_acc(r_acc[OP]) + sx_mf(OD_PR[s] ? mfPrReal[OK*MF_W +: MF_W] : mfMrReal[OK*MF_W +: MF_W]);
    assign w_evI = EV_PR[s] ? mfPrImag[EK*ERR_W +: ERR_W] : mfMrImag[EK*ERR_W +: ERR_W];
    assign w_odI = OD_PR[s] ? mfPrImag[OK*ERR_W +: ERR_W] : mfMrImag[OK*ERR_W +: ERR_W];
    assign w_c1  = r_parity ? w_ev : w_od;

    // Strict compare: a tie keeps the zero branch.
    assign w_sel[s]  = w_c1 > w_c0;
    assign w_win     = w_sel[s] ? w_c1 : w_c0;
    assign w_diff    = w_win - sx_acc(w_bestPrev);
    assign w_new[s]  = (w_diff[SW-1:ACC_W-1] == '0 || w_diff[SW-1:ACC_W-1] == '1) ? w_diff[ACC_W-1:0]
                     : {w_diff[SW-1], {(ACC_W-1){~w_diff[SW-1]}}};
    assign w_pred[s] = w_sel[s] ? (r_parity ? 2'(EP) : 2'(OP)) : 2'(s);
    assign w_img[s]  = w_sel[s] ? (r_parity ? w_evI : w_odI) : mfZrImag[ZK*ERR_W +: ERR_W];
  end

  // Argmax scans from state 0 upward with a strict compare so ties go to the lowest index.
  always_comb begin
    w_bestPrev = r_acc[0];
    w_maxNew   = w_new[0];
    w_bestNew  = 2'd0;
    for (int s = 1; s < 4; s++) begin
      if (r_acc[s] > w_bestPrev) w_bestPrev = r_acc[s];
      if (w_new[s] > w_maxNew) begin
        w_maxNew  = w_new[s];
        w_bestNew = 2'(s);
      end
    end
  end

  assign w_phase = r_img[r_best];
  assign w_neg   = (w_phase == {1'b1, {(ERR_W-1){1'b0}}}) ? {1'b0, {(ERR_W-1){1'b1}}} : -w_phase;

`ifdef SOQPSK_ODD_ERR_EN
  assign w_errUpd = r_vld1;
`else
  assign w_errUpd = r_vld1 & r_even1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 4; s++) begin
        r_acc[s]  <= '0;
        r_path[s] <= '0;
        r_img[s]  <= '0;
      end
      r_sel    <= '0;
      r_best   <= '0;
      r_fill   <= '0;
      r_parity <= 1'b1;
      r_vld1   <= 1'b0;
      r_even1  <= 1'b0;
    end else begin
      r_vld1 <= symEn;
      if (symEn) begin
        for (int s = 0; s < 4; s++) begin
          r_acc[s]  <= w_new[s];
          r_path[s] <= {r_path[w_pred[s]][TB_DEPTH-2:0], w_sel[s]};
          r_img[s]  <= w_img[s];
        end
        r_sel    <= w_sel;
        r_best   <= w_bestNew;
        r_parity <= ~r_parity;
        r_even1  <= r_parity;
        if (r_fill != FC_W'(TB_DEPTH)) r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Output stage reads the symbol just committed; a strobe in the same cycle only affects stage one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec   <= 1'b0;
      r_decEn <= 1'b0;
      r_errEn <= 1'b0;
      r_phase <= '0;
      r_dev   <= '0;
    end else begin
      r_decEn <= r_vld1 && (r_fill == FC_W'(TB_DEPTH));
      r_errEn <= w_errUpd;
      if (r_vld1) r_dec <= r_path[r_best][TB_DEPTH-1];
      if (w_errUpd) begin
        r_phase <= w_phase;
        r_dev   <= r_sel[r_best] ? w_neg : w_phase;
      end
    end
  end

  assign decision   = r_dec;
  assign decEn      = r_decEn;
  assign errEn      = r_errEn;
  assign phaseError = r_phase;
  assign devError   = r_dev;
  assign bestState  = r_best;
  assign symParity  = r_parity;
endmodule

// File: tb/tb_soqpsk_trellis_demod.sv
// Directed bench for soqpsk_trellis_demod with hand-derived metric/traceback expectations.
module tb_soqpsk_trellis_demod;
  localparam int MF_W  = 8;
  localparam int ERR_W = 10;
`ifdef SOQPSK_ODD_ERR_EN
  localparam int ODD = 1;
`else
  localparam int ODD = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic symEn = 1'b0;
  logic [4*MF_W-1:0]  mfZrReal, mfPrReal, mfMrReal;
  logic [4*ERR_W-1:0] mfZrImag, mfPrImag, mfMrImag;
  logic               decision, decEn, errEn, symParity;
  logic [1:0]         bestState;
  logic [ERR_W-1:0]   phaseError, devError;

  int ntests = 0;
  int nfail  = 0;
  int nerr, ndec;

  soqpsk_trellis_demod dut (
    .clk(clk), .reset(reset), .symEn(symEn),
    .mfZrReal(mfZrReal), .mfPrReal(mfPrReal), .mfMrReal(mfMrReal),
    .mfZrImag(mfZrImag), .mfPrImag(mfPrImag), .mfMrImag(mfMrImag),
    .decision(decision), .decEn(decEn), .bestState(bestState),
    .phaseError(phaseError), .devError(devError), .errEn(errEn), .symParity(symParity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int zr, input int pr, input int mr, input int zi, input int pi, input int mi);
    for (int k = 0; k < 4; k++) begin
      mfZrReal[k*MF_W +: MF_W]   = MF_W'(zr);
      mfPrReal[k*MF_W +: MF_W]   = MF_W'(pr);
      mfMrReal[k*MF_W +: MF_W]   = MF_W'(mr);
      mfZrImag[k*ERR_W +: ERR_W] = ERR_W'(zi);
      mfPrImag[k*ERR_W +: ERR_W] = ERR_W'(pi);
      mfMrImag[k*ERR_W +: ERR_W] = ERR_W'(mi);
    end
  endtask

  // One strobe, then sample in the cycle where decEn/errEn for it are high.
  task automatic step();
    @(negedge clk); symEn = 1'b1;
    @(negedge clk); symEn = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; symEn = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    set_all(0, 0, 0, 0, 0, 0);
    do_reset();
    chk("rst decision", decision, 0);
    chk("rst decEn", decEn, 0);
    chk("rst errEn", errEn, 0);
    chk("rst bestState", bestState, 0);
    chk("rst phaseError", $signed(phaseError), 0);
    chk("rst devError", $signed(devError), 0);
    chk("rst symParity", symParity, 1);

    // All-zero inputs: decEn opens at symbol 16, errEn on even symbols (1st, 3rd, ...).
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("zero decEn s%0d", k), decEn, int'(k >= 16));
      chk($sformatf("zero errEn s%0d", k), errEn, int'((k % 2 == 1) || ODD == 1));
    end
    chk("zero decision", decision, 0);
    chk("zero bestState", bestState, 0);
    chk("zero symParity", symParity, 1);

    // Zero branch dominant: metrics settle at +40, every decision 0.
    do_reset();
    set_all(40, -40, -40, 0, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("zr40 decision s%0d", k), decision, 0);
    end
    chk("zr40 bestState", bestState, 0);
    chk("zr40 decEn", decEn, 1);

    // Mr0 favours state0 via the one branch on symbol 1; its sel bit surfaces after 16 symbols.
    do_reset();
    set_all(-50, -50, -50, 0, 0, 0);
    mfMrReal[0 +: MF_W]  = 8'sd100;
    mfMrImag[0 +: ERR_W] = 10'sd12;
    step();
    chk("mr0 bestState", bestState, 0);
    chk("mr0 phaseError", $signed(phaseError), 12);
    chk("mr0 devError", $signed(devError), -12);
    chk("mr0 errEn", errEn, 1);
    chk("mr0 decision s1", decision, 0);
    set_all(0, 0, 0, 0, 0, 0);
    for (int k = 2; k <= 20; k++) begin
      step();
      chk($sformatf("mr0 decision s%0d", k), decision, int'(k == 16));
      chk($sformatf("mr0 decEn s%0d", k), decEn, int'(k >= 16));
      if (k == 2) chk("mr0 hold phaseError", $signed(phaseError), (ODD == 1) ? 0 : 12);
    end

    // Non-zero bestState, odd-symbol table with lowest-index tie, then a zero-branch error term.
    do_reset();
    set_all(-50, -50, -50, 0, 0, 0);
    mfPrReal[1*MF_W +: MF_W]   = 8'sd100;
    mfPrImag[1*ERR_W +: ERR_W] = 10'sd7;
    step();
    chk("pr1 bestState", bestState, 1);
    chk("pr1 phaseError", $signed(phaseError), 7);
    chk("pr1 devError", $signed(devError), -7);
    set_all(-50, -50, -50, 0, 0, 0);
    mfMrReal[3*MF_W +: MF_W] = 8'sd100;
    step();
    chk("odd tie bestState", bestState, 0);
    chk("odd errEn", errEn, ODD);
    chk("odd phaseError", $signed(phaseError), (ODD == 1) ? 0 : 7);
    chk("odd devError", $signed(devError), (ODD == 1) ? 0 : -7);
    set_all(0, 0, 0, 0, 0, 0);
    mfZrImag[3*ERR_W +: ERR_W] = 10'sd5;
    step();
    chk("zr3 bestState", bestState, 0);
    chk("zr3 phaseError", $signed(phaseError), 5);
    chk("zr3 devError", $signed(devError), 5);
    chk("zr3 errEn", errEn, 1);

    // Most-negative imaginary value on a sel=1 winner saturates the negation.
    do_reset();
    set_all(-50, -50, -50, 0, 0, 0);
    mfMrReal[0 +: MF_W]  = 8'sd100;
    mfMrImag[0 +: ERR_W] = 10'h200;
    step();
    chk("sat phaseError", $signed(phaseError), -512);
    chk("sat devError", $signed(devError), 511);
    set_all(0, 0, 0, 9, 9, 9);
    for (int k = 2; k <= 10; k++) step();
    chk("pre-rst phaseError", $signed(phaseError), 9);
    chk("pre-rst symParity", symParity, 1);
    chk("pre-rst decEn", decEn, 0);

    // Reset coincident with a strobe: reset wins, parity stays 1.
    @(negedge clk); reset = 1'b1; symEn = 1'b1;
    @(negedge clk); reset = 1'b0; symEn = 1'b0;
    chk("mid-rst phaseError", $signed(phaseError), 0);
    chk("mid-rst devError", $signed(devError), 0);
    chk("mid-rst symParity", symParity, 1);
    chk("mid-rst bestState", bestState, 0);
    chk("mid-rst decEn", decEn, 0);
    chk("mid-rst errEn", errEn, 0);

    // 15 back-to-back strobes: all processed, fill not yet reached.
    set_all(0, 0, 0, 0, 0, 0);
    nerr = 0;
    ndec = 0;
    symEn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 14) symEn = 1'b0;
      nerr += int'(errEn);
      ndec += int'(decEn);
    end
    chk("burst errEn pulses", nerr, (ODD == 1) ? 15 : 8);
    chk("burst decEn pulses", ndec, 0);
    chk("burst symParity", symParity, 0);
    step();
    chk("refill decEn s16", decEn, 1);
    chk("refill symParity", symParity, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/soqpsk_trellis_demod.md
SOQPSK_TRELLIS_DEMOD -- requirements
Module: soqpsk_trellis_demod

Interface
REQ-001 SHALL have parameter MF_W, default 8: signed width of each real matched-filter input.
REQ-002 SHALL have parameter ERR_W, default 10: signed width of each imaginary input and of each error output.
REQ-003 SHALL have parameter TB_DEPTH, default 16, legal range 4..64: survivor depth in symbols.
REQ-004 SHALL have parameter ACC_W, default MF_W+4: signed path-metric width.
REQ-005 SHALL use reset, synchronous, active-high, and clock clk.
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 symEn  in  1  one-cycle symbol strobe.
REQ-009 mfZrReal, mfPrReal, mfMrReal  in  4*MF_W each  real zero/+/- rotation filter outputs; rotation k occupies bits [k*MF_W +: MF_W].
REQ-010 mfZrImag, mfPrImag, mfMrImag  in  4*ERR_W each  imaginary parts, packed like REQ-009.
REQ-011 decision  out  1  traced-back bit.
REQ-012 decEn  out  1  one-cycle strobe marking an updated decision.
REQ-013 bestState  out  2  index of the largest metric.
REQ-014 phaseError, devError  out  ERR_W each  loop error terms.
REQ-015 errEn  out  1  one-cycle strobe marking updated error terms.
REQ-016 symParity  out  1  1 = the next symbol is even.

Function
REQ-017 SHALL run a 4-state add-compare-select (ACS) update on each symEn; every symEn SHALL be processed, including back-to-back strobes.
REQ-018 The zero-branch candidates SHALL be: state0 = acc0+Zr3, state1 = acc1+Zr2, state2 = acc2+Zr0, state3 = acc3+Zr1.
REQ-019 On even symbols, the one-branch candidates SHALL be: s0 = acc2+Mr0, s1 = acc3+Pr1, s2 = acc0+Pr3, s3 = acc1+Mr2.
REQ-020 On odd symbols, the one-branch candidates SHALL be: s0 = acc1+Pr2, s1 = acc0+Mr3, s2 = acc3+Mr1, s3 = acc2+Pr0.
REQ-021 Each state SHALL select the larger candidate and record sel=1 when the one branch wins; a tie SHALL select the zero branch (sel=0).
REQ-022 Normalisation: new metric = winner - bestMetricPrev, where bestMetricPrev is the largest metric registered at the previous symbol; inputs SHALL be sign-extended, and the result SHALL saturate to the most-negative ACC_W value.
REQ-023 bestState SHALL equal argmax of the new metrics and SHALL be registered at the symEn edge; ties SHALL resolve to the lowest index.
REQ-024 Traceback SHALL be a register exchange: path[s] <= {path[pred(s)][TB_DEPTH-2:0], sel[s]}, where pred(s) is the source state of the winning branch.
REQ-025 The per-state winning imaginary value SHALL be registered alongside the winning metric.
REQ-026 Latency: symEn in cycle n -> decision, phaseError and devError update at the end of cycle n+1; decEn and errEn SHALL be high in cycle n+2 only.
REQ-027 decision SHALL equal path[bestState][TB_DEPTH-1].
REQ-028 A fill counter SHALL count symbols and saturate at TB_DEPTH; decEn SHALL be suppressed until TB_DEPTH symbols have been processed.
REQ-029 phaseError SHALL equal the winning imaginary value of bestState.
REQ-030 devError SHALL equal phaseError when sel[bestState]=0, and its two's-complement negation otherwise; negating the most-negative value SHALL saturate to the most-positive value.
REQ-031 symParity SHALL toggle on every symEn.

Reset
REQ-032 On reset: all metrics, paths, the fill counter, bestState, decision, phaseError, devError, decEn and errEn SHALL be cleared to 0, and symParity SHALL be set to 1.
REQ-033 Reset SHALL override a coincident symEn.
REQ-034 Reset mid-operation SHALL restart the fill interval, with no decEn until TB_DEPTH new symbols have been processed.

Configuration
REQ-035 Macro SOQPSK_ODD_ERR_EN: when defined, errEn and the error terms SHALL update on every symbol.
REQ-036 When SOQPSK_ODD_ERR_EN is undefined, errEn and the error terms SHALL update on even symbols only, and SHALL hold their values on odd symbols.

Verification
REQ-037 Reset, then 20 symEn with all inputs 0 -> decEn first high after the 16th symbol, decision 0, bestState 0.
REQ-038 Zr = +40 and Pr = Mr = -40 on all rotations for 40 symbols -> every decision 0, and no metric saturates.
REQ-039 Even-symbol Mr0 = +100 with all other inputs -50, state0 favoured -> sel[0]=1, and after 16 symbols decision 1 emerges at TB_DEPTH latency.
REQ-040 Imaginary input of 12 on the winning branch with sel=1 -> phaseError = 12, devError = -12; with the imaginary input at the most-negative value (-512 at ERR_W=10) -> devError = +511.
REQ-041 Without SOQPSK_ODD_ERR_EN: errEn on alternate symbols only; with it: errEn on every symbol.
REQ-042 Assert reset at symbol 10 of 30 -> outputs cleared next cycle, symParity = 1, and decEn silent for 16 symbols.
